// File: rtl/reg_file_pkg.sv
// Shared defaults and address type for the register file.
package reg_file_pkg;
    localparam int ELEM_WIDTH_DEF = 32;
    localparam int NUM_REGS_DEF   = 32;
    localparam int ADDR_W_DEF     = $clog2(NUM_REGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] addr_t;
endpackage

// File: rtl/reg_file_register.sv
// Single storage entry: loads d_i when en_i, resets asynchronously to RESET_VALUE.
module register #(
    parameter int                 WIDTH       = 32,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni)  q_o <= RESET_VALUE;
        else if (en_i) q_o <= d_i;
    end
endmodule

// File: rtl/reg_file.sv
// 1W/2R register file with registered reads; entry 0 is hardwired to RESET_VALUE.
// Define REG_FILE_BYPASS_EN to forward same-edge write data to a colliding read.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int                      ELEM_WIDTH  = ELEM_WIDTH_DEF,
    parameter int                      NUM_REGS    = NUM_REGS_DEF,
    parameter logic [ELEM_WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic                        clk_i,
    input  logic                        arst_ni,
    input  logic                        we_i,
    input  logic [$clog2(NUM_REGS)-1:0] waddr_i,
    input  logic [ELEM_WIDTH-1:0]       wdata_i,
    input  logic                        re_a_i,
    input  logic                        re_b_i,
    input  logic [$clog2(NUM_REGS)-1:0] raddr_a_i,
    input  logic [$clog2(NUM_REGS)-1:0] raddr_b_i,
    output logic [ELEM_WIDTH-1:0]       rdata_a_o,
    output logic [ELEM_WIDTH-1:0]       rdata_b_o,
    output logic                        rvalid_a_o,
    output logic                        rvalid_b_o
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [ELEM_WIDTH-1:0]      mem [NUM_REGS];
    logic [1:0]                 re;
    logic [1:0][ADDR_W-1:0]     raddr;

    assign re    = {re_b_i, re_a_i};
    assign raddr = {raddr_b_i, raddr_a_i};

    // Entry 0 has no storage; it is a constant.
    assign mem[0] = RESET_VALUE;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        register #(
            .WIDTH       (ELEM_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_reg (
            .clk_i   (clk_i),
            .arst_ni (arst_ni),
            .en_i    (we_i && (waddr_i == ADDR_W'(i))),
            .d_i     (wdata_i),
            .q_o     (mem[i])
        );
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  hit;
        logic [ELEM_WIDTH-1:0] rd_q;
        logic                  vld_q;

`ifdef REG_FILE_BYPASS_EN
        assign hit = we_i && (raddr[p] == waddr_i) && (waddr_i != '0);
`else
        assign hit = 1'b0;
`endif

        always_ff @(posedge clk_i or negedge arst_ni) begin
            if (!arst_ni) begin
                rd_q  <= RESET_VALUE;
                vld_q <= 1'b0;
            end else begin
                vld_q <= re[p];
                if (re[p]) rd_q <= hit ? wdata_i : mem[raddr[p]];
            end
        end
    end

    assign rdata_a_o  = g_port[0].rd_q;
    assign rdata_b_o  = g_port[1].rd_q;
    assign rvalid_a_o = g_port[0].vld_q;
    assign rvalid_b_o = g_port[1].vld_q;
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file against an array-based reference model.
module tb_reg_file;
    localparam int W = 32;
    localparam int N = 32;
    localparam int AW = 5;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          arst_ni;
    logic          we_i, re_a_i, re_b_i;
    logic [AW-1:0] waddr_i, raddr_a_i, raddr_b_i;
    logic [W-1:0]  wdata_i;
    logic [W-1:0]  rdata_a_o, rdata_b_o;
    logic          rvalid_a_o, rvalid_b_o;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [W-1:0] model [N];
    logic [W-1:0] exp_a, exp_b;
    logic         exp_va, exp_vb;

    reg_file dut (
        .clk_i(clk_i), .arst_ni(arst_ni), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .re_a_i(re_a_i), .re_b_i(re_b_i), .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
        .rdata_a_o(rdata_a_o), .rdata_b_o(rdata_b_o), .rvalid_a_o(rvalid_a_o), .rvalid_b_o(rvalid_b_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_reset();
        for (int i = 0; i < N; i++) model[i] = '0;
        exp_a = '0; exp_b = '0; exp_va = 1'b0; exp_vb = 1'b0;
    endtask

    // Advance one rising edge, updating the model from the inputs seen at that edge.
    task automatic tick();
        logic collide_a, collide_b;
        collide_a = BYPASS && we_i && (raddr_a_i == waddr_i) && (waddr_i != 0);
        collide_b = BYPASS && we_i && (raddr_b_i == waddr_i) && (waddr_i != 0);
        if (arst_ni) begin
            exp_va = re_a_i;
            exp_vb = re_b_i;
            if (re_a_i) exp_a = collide_a ? wdata_i : model[raddr_a_i];
            if (re_b_i) exp_b = collide_b ? wdata_i : model[raddr_b_i];
            if (we_i && waddr_i != 0) model[waddr_i] = wdata_i;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        we_i = 0; re_a_i = 0; re_b_i = 0;
        waddr_i = '0; raddr_a_i = '0; raddr_b_i = '0; wdata_i = '0;
    endtask

    task automatic test_reset();
        idle();
        arst_ni = 1'b0;
        model_reset();
        re_a_i = 1; re_b_i = 1; we_i = 1; wdata_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 12; i++) begin
            raddr_a_i = AW'(i); raddr_b_i = AW'(31 - i); waddr_i = AW'(i + 1);
            @(posedge clk_i); #1;
            checks++;
            if (rdata_a_o !== '0 || rdata_b_o !== '0 || rvalid_a_o !== 1'b0 || rvalid_b_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: rd_a=%h rd_b=%h va=%b vb=%b, want 0/0/0/0",
                         rdata_a_o, rdata_b_o, rvalid_a_o, rvalid_b_o);
            end
        end
        idle();
        arst_ni = 1'b1;
        checks++;
        if (rvalid_a_o !== 1'b0 || rvalid_b_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_valid: va=%b vb=%b, want 0", rvalid_a_o, rvalid_b_o);
        end
        for (int i = 0; i < N; i++) begin
            re_a_i = 1; re_b_i = 1; raddr_a_i = AW'(i); raddr_b_i = AW'(N - 1 - i);
            tick();
            checks++;
            if (rdata_a_o !== 32'h0 || rdata_b_o !== 32'h0 || rvalid_a_o !== 1'b1 || rvalid_b_o !== 1'b1) begin
                errors++;
                $display("FAIL reset_content[%0d]: rd_a=%h rd_b=%h va=%b vb=%b, want 0/0/1/1",
                         i, rdata_a_o, rdata_b_o, rvalid_a_o, rvalid_b_o);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_write_read();
        idle();
        we_i = 1; waddr_i = 5; wdata_i = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (rvalid_a_o !== 1'b0) begin
            errors++; $display("FAIL wr_no_valid: va=%b, want 0", rvalid_a_o);
        end
        idle();
        re_a_i = 1; raddr_a_i = 5;
        tick();
        checks++;
        if (rdata_a_o !== 32'hDEAD_BEEF || rvalid_a_o !== 1'b1) begin
            errors++;
            $display("FAIL write_read: rd=%h va=%b, want deadbeef/1", rdata_a_o, rvalid_a_o);
        end
        idle();
        raddr_a_i = 0;
        tick();
        checks++;
        if (rdata_a_o !== 32'hDEAD_BEEF || rvalid_a_o !== 1'b0) begin
            errors++;
            $display("FAIL read_hold: rd=%h va=%b, want deadbeef/0", rdata_a_o, rvalid_a_o);
        end
    endtask

    task automatic test_entry0();
        idle();
        we_i = 1; waddr_i = 0; wdata_i = 32'h1234_5678;
        tick();
        idle();
        re_b_i = 1; raddr_b_i = 0;
        tick();
        checks++;
        if (rdata_b_o !== 32'h0 || rvalid_b_o !== 1'b1) begin
            errors++;
            $display("FAIL entry0: rd=%h va=%b, want 00000000/1", rdata_b_o, rvalid_b_o);
        end
    endtask

    task automatic test_collision();
        logic [W-1:0] want;
        want = BYPASS ? 32'h2 : 32'h1;
        idle();
        we_i = 1; waddr_i = 7; wdata_i = 32'h1;
        tick();
        we_i = 1; waddr_i = 7; wdata_i = 32'h2; re_a_i = 1; raddr_a_i = 7;
        tick();
        checks++;
        if (rdata_a_o !== want) begin
            errors++; $display("FAIL collision: rd=%h, want %h", rdata_a_o, want);
        end
        idle();
        re_a_i = 1; raddr_a_i = 7;
        tick();
        checks++;
        if (rdata_a_o !== 32'h2) begin
            errors++; $display("FAIL collision_after: rd=%h, want 00000002", rdata_a_o);
        end
        idle();
    endtask

    task automatic test_dual_read();
        idle();
        we_i = 1; waddr_i = 3; wdata_i = 32'hA;
        tick();
        waddr_i = 9; wdata_i = 32'hB;
        tick();
        idle();
        re_a_i = 1; re_b_i = 1; raddr_a_i = 3; raddr_b_i = 9;
        tick();
        checks++;
        if (rdata_a_o !== 32'hA || rdata_b_o !== 32'hB || rvalid_a_o !== 1'b1 || rvalid_b_o !== 1'b1) begin
            errors++;
            $display("FAIL dual_read: a=%h b=%h va=%b vb=%b, want a/b/1/1", rdata_a_o, rdata_b_o, rvalid_a_o, rvalid_b_o);
        end
        raddr_a_i = 9;
        tick();
        checks++;
        if (rdata_a_o !== 32'hB || rdata_b_o !== 32'hB) begin
            errors++; $display("FAIL dual_same: a=%h b=%h, want b/b", rdata_a_o, rdata_b_o);
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1000; c++) begin
            we_i      = 1'($urandom);
            waddr_i   = AW'($urandom);
            wdata_i   = $urandom;
            re_a_i    = 1'($urandom);
            re_b_i    = 1'($urandom);
            raddr_a_i = ($urandom_range(0, 3) == 0) ? waddr_i : AW'($urandom);
            raddr_b_i = ($urandom_range(0, 3) == 0) ? raddr_a_i : AW'($urandom);
            if (c == 500) begin
                we_i = 1; re_a_i = 1; re_b_i = 1;
                arst_ni = 1'b0;
                model_reset();
                #1;
                checks++;
                if (rdata_a_o !== '0 || rdata_b_o !== '0 || rvalid_a_o !== 1'b0 || rvalid_b_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_async_reset: a=%h b=%h va=%b vb=%b, want 0", rdata_a_o, rdata_b_o, rvalid_a_o, rvalid_b_o);
                end
                #2 arst_ni = 1'b1;
                #1;
                checks++;
                if (rvalid_a_o !== 1'b0 || rvalid_b_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_release_valid: va=%b vb=%b, want 0", rvalid_a_o, rvalid_b_o);
                end
            end
            tick();
            checks++;
            if (rdata_a_o !== exp_a || rdata_b_o !== exp_b || rvalid_a_o !== exp_va || rvalid_b_o !== exp_vb) begin
                errors++;
                $display("FAIL random[%0d]: a=%h b=%h va=%b vb=%b, want a=%h b=%h va=%b vb=%b",
                         c, rdata_a_o, rdata_b_o, rvalid_a_o, rvalid_b_o, exp_a, exp_b, exp_va, exp_vb);
            end
        end
        idle();
    endtask

    initial begin
        arst_ni = 1'b0;
        idle();
        model_reset();
        test_reset();
        test_write_read();
        test_entry0();
        test_collision();
        test_dual_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
